// File: rtl/aurora_seq_strip_if.sv
// AXI-Stream beat bundle (tvalid/tdata/tlast/tready) used on both sides of aurora_seq_strip.
interface aurora_seq_strip_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/aurora_seq_strip.sv
// Aurora RX trailer strip: drops the {16'h0, seq} word ending each frame, moves tlast
// onto the last payload word, checks seq continuity and keeps status counters.
module aurora_seq_strip #(
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] SEQ_INIT  = 16'h0001
) (
  input  logic                 m_axis_aclk,
  input  logic                 m_axis_aresetn,
  input  logic                 ctrl_strip_seq_en,
  input  logic                 stat_clr,
  aurora_seq_strip_if.slave    s_axis,
  aurora_seq_strip_if.master   m_axis,
  output logic                 seq_err,
  output logic [15:0]          stat_seq_last,
  output logic [CNT_WIDTH-1:0] stat_seq_err_cnt,
  output logic [CNT_WIDTH-1:0] stat_fmt_err_cnt,
  output logic [CNT_WIDTH-1:0] stat_empty_cnt,
  output logic [31:0]          stat_frame_cnt
);

  logic        mode;
  logic        in_frame;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic [15:0] seq_exp;
  logic        s_rdy;
  logic        s_fire;
  logic        trailer;
  logic        idle;
  logic [15:0] seq;

  always_comb begin
    if (mode) begin
      // a held word can only leave once the next beat tells us whether it is last
      m_axis.tvalid = hold_valid & s_axis.tvalid;
      m_axis.tdata  = hold_data;
      m_axis.tlast  = s_axis.tlast;
      s_rdy         = !hold_valid | m_axis.tready;
    end else begin
      m_axis.tvalid = s_axis.tvalid;
      m_axis.tdata  = s_axis.tdata;
      m_axis.tlast  = s_axis.tlast;
      s_rdy         = m_axis.tready;
    end
  end

  assign s_axis.tready = s_rdy;
  assign s_fire  = s_axis.tvalid & s_rdy;
  assign trailer = mode & s_fire & s_axis.tlast;
  assign idle    = !hold_valid & !in_frame;
  assign seq     = s_axis.tdata[15:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      mode             <= 1'b1;
      in_frame         <= 1'b0;
      hold_valid       <= 1'b0;
      hold_data        <= '0;
      seq_exp          <= SEQ_INIT;
      seq_err          <= 1'b0;
      stat_seq_last    <= '0;
      stat_seq_err_cnt <= '0;
      stat_fmt_err_cnt <= '0;
      stat_empty_cnt   <= '0;
      stat_frame_cnt   <= '0;
    end else begin
      seq_err <= 1'b0;
      if (s_fire) in_frame <= !s_axis.tlast;
      // mode only changes between frames, including right after a single-beat frame
      if (idle && (!s_fire || s_axis.tlast)) mode <= ctrl_strip_seq_en;

      if (mode && s_fire) begin
        if (!s_axis.tlast) begin
          hold_data  <= s_axis.tdata;
          hold_valid <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
        end
      end

      if (trailer) begin
        stat_seq_last <= seq;
        seq_exp       <= seq + 16'd1;
        if (seq != seq_exp) seq_err <= 1'b1;
      end

      if (stat_clr) begin
        stat_seq_err_cnt <= '0;
        stat_fmt_err_cnt <= '0;
        stat_empty_cnt   <= '0;
        stat_frame_cnt   <= '0;
      end else begin
        if (s_fire && s_axis.tlast) stat_frame_cnt <= stat_frame_cnt + 32'd1;
        if (trailer && seq != seq_exp) stat_seq_err_cnt <= sat_inc(stat_seq_err_cnt);
        if (trailer && s_axis.tdata[31:16] != 16'h0) stat_fmt_err_cnt <= sat_inc(stat_fmt_err_cnt);
        if (trailer && !hold_valid) stat_empty_cnt <= sat_inc(stat_empty_cnt);
      end
    end
  end

endmodule
